multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the RV32I core datapath.
- Drives instruction fetch, decode (selects the immediate format for the immediate generator), execute, memory and writeback.
- Owns the single shared memory port handshake and detects illegal opcodes and memory timeouts.
- Sits between the instruction register, the ALU/branch comparator and the register file/PC write enables.

Parameters:
- MEM_TIMEOUT, 16: cycles mem_req may stay pending without mem_ready before a bus trap.
- TIMEOUT_W, 5: width of the wait counter; must satisfy 2^TIMEOUT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  7  instruction register bits [6:0]
- branch_taken  input  1  comparator result for the current B-type instruction
- mem_ready  input  1  memory completes the pending request this cycle
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  1 = store, 0 = read
- mem_src  output  1  address select: 0 = PC (fetch), 1 = ALU result (data)
- ir_write  output  1  latch fetched word into the instruction register
- imm_sel  output  3  0=I, 1=S, 2=B, 3=U, 4=J, 7=none
- alu_src_a  output  1  0 = rs1, 1 = PC
- alu_src_b  output  1  0 = rs2, 1 = immediate
- alu_op  output  2  0=add, 1=funct-decoded, 2=pass-B (LUI)
- reg_write  output  1  register file write strobe
- wb_sel  output  2  0=ALU, 1=memory data, 2=PC+4
- pc_write  output  1  PC update strobe
- pc_src  output  2  0=PC+4, 1=PC+imm, 2=ALU result (JALR, bit0 cleared by datapath)
- state  output  3  current state, for debug
- trap  output  1  sticky fault indication
- trap_cause  output  2  0=none, 1=illegal opcode, 2=memory timeout
- instret  output  32  retired instruction count (see Optional Feature)

Behaviour:
- Registered: state, wait counter, trap_cause, instret. All other outputs are combinational from state, opcode, mem_ready and branch_taken.
- Reset: state=FETCH(0), counter=0, trap_cause=0, instret=0. Every strobe (mem_req, ir_write, reg_write, pc_write, mem_we) is forced 0 while reset=1.
- Reset mid-operation abandons the instruction with no PC or register write. Fetch restarts the cycle after reset deasserts.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP with cause 1.
- FETCH: mem_req=1, mem_src=0, mem_we=0. On mem_ready: ir_write=1, next state DECODE.
- DECODE: one cycle. imm_sel from opcode: 0010011/0000011/1100111 give I; 0100011 gives S; 1100011 gives B; 0110111/0010111 give U; 1101111 gives J. Any other opcode: trap_cause=1, next state TRAP, no strobes. Legal opcode: next state EXEC.
- imm_sel is held valid for the current opcode in DECODE, EXEC, MEM and WB.
- EXEC:
  - Branch: pc_write=1, pc_src = branch_taken ? 1 : 0, next state FETCH.
  - Load/store: alu_src_b=1, alu_op=0, next state MEM.
  - JAL/AUIPC: alu_src_a=1, alu_src_b=1, next state WB.
  - LUI: alu_op=2. OP-IMM: alu_op=1. JALR: alu_op=0. All three next state WB.
- MEM: mem_req=1, mem_src=1, mem_we=1 for store. On mem_ready, store: pc_write=1, pc_src=0, next state FETCH. On mem_ready, load: next state WB.
- WB: reg_write=1, pc_write=1, next state FETCH.
  - wb_sel: 1 for load, 2 for JAL/JALR, otherwise 0.
  - pc_src: 1 for JAL, 2 for JALR, otherwise 0.
- Latency with zero-wait memory (mem_ready in the first request cycle): branch 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5.
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0.
  - Clears on mem_ready and on every state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: trap_cause=2, next state TRAP.
  - mem_ready in the same cycle the counter hits the limit wins, so no trap.
- mem_ready while mem_req=0 is ignored.
- TRAP: trap=1, all strobes 0. Exited only by reset. trap_cause holds its value.

Optional Feature:
- RETIRE_COUNTER_EN defined: instret increments by 1 on every pc_write-qualified completion, i.e. the exit from EXEC (branch), MEM (store) or WB. It wraps 0xFFFFFFFF to 0 and does not count trapped instructions.
- Not defined: instret is driven constant 0 and no counter flops are inferred.

Test Plan:
- Zero-wait memory, IR=0x00500093 (addi x1,x0,5) -> states 0,1,2,4,0. imm_sel=0, alu_src_b=1, reg_write=1 and wb_sel=0 in WB, instret=1.
- lw with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with mem_src=1, mem_we=0. WB has wb_sel=1. Total 8 cycles.
- beq with branch_taken=1, then branch_taken=0 -> pc_src=1, then pc_src=0, with pc_write=1 in EXEC. reg_write never asserted.
- IR opcode 0x7F -> TRAP after DECODE, trap_cause=1, trap held for 20 cycles. Reset returns state to 0 with trap=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP with trap_cause=2 after 4 stall cycles. A second run with mem_ready on the 4th cycle shows no trap.
- Reset asserted in MEM of a sw -> mem_req, mem_we and pc_write are 0 that cycle. FETCH resumes next cycle with instret unchanged.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// -----------------------
// Multi-cycle sequencer for the RV32I core datapath. It steps each
// instruction through FETCH, DECODE, EXEC, MEM and WB. It owns the single
// shared memory port handshake and traps on illegal opcodes or memory stalls.
//
// Optional feature macro: RETIRE_COUNTER_EN
//   Defined     : instret counts completed (PC-writing) instructions.
//   Not defined : instret is tied to 0 and no counter flops exist.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   opcode[6:0]             instruction register bits [6:0]
//   branch_taken            comparator result for the current branch
//   mem_ready               memory completes the pending request this cycle
//   mem_req, mem_we         memory request / store select
//   mem_src                 0 = PC (fetch) address, 1 = ALU result address
//   ir_write                latch the fetched word into the IR
//   imm_sel[2:0]            0=I 1=S 2=B 3=U 4=J 7=none
//   alu_src_a, alu_src_b    0 = rs1/rs2, 1 = PC/immediate
//   alu_op[1:0]             0=add 1=funct-decoded 2=pass-B
//   reg_write, wb_sel[1:0]  register write strobe, 0=ALU 1=mem 2=PC+4
//   pc_write, pc_src[1:0]   PC strobe, 0=PC+4 1=PC+imm 2=ALU result
//   state[2:0]              current state, for debug
//   trap, trap_cause[1:0]   sticky fault, 0=none 1=illegal 2=mem timeout
//   instret[31:0]           retired instruction count
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMEOUT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_src,
    output logic        ir_write,
    output logic [2:0]  imm_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // The last stalled cycle is the one where the counter already holds
    // MEM_TIMEOUT-1; a mem_ready in that same cycle still completes.
    localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);

    state_t               state_q, next_state;
    logic [TIMEOUT_W-1:0] wait_cnt_q, next_wait;
    logic [1:0]           cause_q, next_cause;

    logic is_load, is_store, is_branch, is_jal, is_jalr, is_opimm, is_lui, is_auipc;
    logic legal;
    logic [2:0] imm_dec;

    logic mem_req_c, mem_we_c, ir_write_c, reg_write_c, pc_write_c;

    // Opcode classification and the immediate format each class uses.
    always_comb begin
        is_load   = (opcode == 7'b0000011);
        is_store  = (opcode == 7'b0100011);
        is_branch = (opcode == 7'b1100011);
        is_jal    = (opcode == 7'b1101111);
        is_jalr   = (opcode == 7'b1100111);
        is_opimm  = (opcode == 7'b0010011);
        is_lui    = (opcode == 7'b0110111);
        is_auipc  = (opcode == 7'b0010111);
        legal     = is_load | is_store | is_branch | is_jal | is_jalr |
                    is_opimm | is_lui | is_auipc;
        imm_dec = 3'd7;
        if (is_opimm || is_load || is_jalr) imm_dec = 3'd0;
        else if (is_store)                  imm_dec = 3'd1;
        else if (is_branch)                 imm_dec = 3'd2;
        else if (is_lui || is_auipc)        imm_dec = 3'd3;
        else if (is_jal)                    imm_dec = 3'd4;
    end

    // Next-state and datapath controls. ALU selects stay valid from EXEC
    // through WB so that JALR's target and the MEM address remain stable.
    always_comb begin
        next_state  = state_q;
        next_cause  = cause_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_src     = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        pc_write_c  = 1'b0;
        pc_src      = 2'd0;
        wb_sel      = 2'd0;
        imm_sel     = 3'd7;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        alu_op      = 2'd0;

        if (state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB)
            imm_sel = imm_dec;

        if (state_q == EXEC || state_q == MEM || state_q == WB) begin
            alu_src_a = is_jal | is_auipc;
            alu_src_b = ~is_branch;
            if (is_lui)        alu_op = 2'd2;
            else if (is_opimm) alu_op = 2'd1;
        end

        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    next_state = DECODE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    next_state = TRAP;
                    next_cause = 2'd2;
                end
            end
            DECODE: begin
                if (legal) begin
                    next_state = EXEC;
                end else begin
                    next_state = TRAP;
                    next_cause = 2'd1;
                end
            end
            EXEC: begin
                if (is_branch) begin
                    pc_write_c = 1'b1;
                    pc_src     = branch_taken ? 2'd1 : 2'd0;
                    next_state = FETCH;
                end else if (is_load || is_store) begin
                    next_state = MEM;
                end else begin
                    next_state = WB;
                end
            end
            MEM: begin
                mem_req_c = 1'b1;
                mem_src   = 1'b1;
                mem_we_c  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write_c = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WB;
                    end
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    next_state = TRAP;
                    next_cause = 2'd2;
                end
            end
            WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                if (is_load)                wb_sel = 2'd1;
                else if (is_jal || is_jalr) wb_sel = 2'd2;
                if (is_jal)       pc_src = 2'd1;
                else if (is_jalr) pc_src = 2'd2;
                next_state = FETCH;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = TRAP;
                next_cause = 2'd1;
            end
        endcase

        // The stall counter only runs while a request is outstanding in one state.
        if (next_state != state_q || mem_ready || !mem_req_c)
            next_wait = '0;
        else
            next_wait = wait_cnt_q + TIMEOUT_W'(1);
    end

    // Sequencer state, stall counter and sticky trap cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            cause_q    <= 2'd0;
        end else begin
            state_q    <= next_state;
            wait_cnt_q <= next_wait;
            cause_q    <= next_cause;
        end
    end

    // Strobes are suppressed during reset so an abandoned instruction
    // cannot write memory, the register file or the PC.
    assign mem_req    = mem_req_c   & ~reset;
    assign mem_we     = mem_we_c    & ~reset;
    assign ir_write   = ir_write_c  & ~reset;
    assign reg_write  = reg_write_c & ~reset;
    assign pc_write   = pc_write_c  & ~reset;
    assign state      = state_q;
    assign trap       = (state_q == TRAP);
    assign trap_cause = cause_q;

`ifdef RETIRE_COUNTER_EN
    logic [31:0] instret_q;

    // Every instruction completes with exactly one PC write, so that strobe
    // marks retirement; trapped instructions never reach it.
    always_ff @(posedge clk) begin
        if (reset)
            instret_q <= 32'd0;
        else if (pc_write)
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
// Directed bench for multicycle_control_unit (MEM_TIMEOUT=4). Each step
// drives inputs on the falling edge, queues the expected output vector and
// compares it shortly after. instret expectations follow RETIRE_COUNTER_EN.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'h13;
    logic        branch_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_src, ir_write;
    logic [2:0]  imm_sel;
    logic        alu_src_a, alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;

    // {st, req we src irw rw pw, pc_src, wb_sel, imm_sel, asa asb, alu_op, trap, cause}
    typedef logic [22:0] exp_t;

    localparam logic [6:0] ADDI = 7'h13;
    localparam logic [6:0] LW   = 7'h03;
    localparam logic [6:0] SW   = 7'h23;
    localparam logic [6:0] BEQ  = 7'h63;
    localparam logic [6:0] ILL  = 7'h7F;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .TIMEOUT_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_src(mem_src),
        .ir_write(ir_write), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src), .state(state),
        .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ret_exp(input int n);
`ifdef RETIRE_COUNTER_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n - n);
`endif
    endfunction

    task automatic apply_stimulus(input logic rst, input logic [6:0] opc, input logic rdy,
                                  input logic tkn, input exp_t e, input string tag);
        @(negedge clk);
        reset        = rst;
        opcode       = opc;
        mem_ready    = rdy;
        branch_taken = tkn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_output();
        exp_t  e;
        exp_t  obs;
        string tag;
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            obs = {state, mem_req, mem_we, mem_src, ir_write, reg_write, pc_write,
                   pc_src, wb_sel, imm_sel, alu_src_a, alu_src_b, alu_op, trap, trap_cause};
            assert (obs === e) else begin
                n_fail++;
                $error("[TB] FAIL %s: observed %06h expected %06h", tag, obs, e);
            end
        end
    endtask

    task automatic check_instret(input logic [31:0] e, input string tag);
        n_checks++;
        assert (instret === e) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed instret %0d expected %0d", tag, instret, e);
        end
    endtask

    task automatic step(input logic rst, input logic [6:0] opc, input logic rdy,
                        input logic tkn, input exp_t e, input string tag);
        apply_stimulus(rst, opc, rdy, tkn, e, tag);
        check_output();
    endtask

    initial begin
        $display("[TB] start");
        // reset: strobes forced low in FETCH
        step(1, ADDI, 1, 0, {3'd0, 6'b000000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "reset0");
        check_instret(32'd0, "reset_instret");
        step(1, ADDI, 0, 0, {3'd0, 6'b000000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "reset1");

        // addi x1,x0,5 with zero-wait memory: 0,1,2,4
        step(0, ADDI, 1, 0, {3'd0, 6'b100100, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "addi_fetch");
        step(0, ADDI, 0, 0, {3'd1, 6'b000000, 2'd0, 2'd0, 3'd0, 2'b00, 2'd0, 1'b0, 2'd0}, "addi_decode");
        step(0, ADDI, 0, 0, {3'd2, 6'b000000, 2'd0, 2'd0, 3'd0, 2'b01, 2'd1, 1'b0, 2'd0}, "addi_exec");
        step(0, ADDI, 0, 0, {3'd4, 6'b000011, 2'd0, 2'd0, 3'd0, 2'b01, 2'd1, 1'b0, 2'd0}, "addi_wb");

        // lw with mem_ready delayed 3 cycles in MEM: 8 cycles total
        step(0, LW, 1, 0, {3'd0, 6'b100100, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "lw_fetch");
        check_instret(ret_exp(1), "addi_instret");
        step(0, LW, 0, 0, {3'd1, 6'b000000, 2'd0, 2'd0, 3'd0, 2'b00, 2'd0, 1'b0, 2'd0}, "lw_decode");
        step(0, LW, 0, 0, {3'd2, 6'b000000, 2'd0, 2'd0, 3'd0, 2'b01, 2'd0, 1'b0, 2'd0}, "lw_exec");
        for (int i = 0; i < 3; i++)
            step(0, LW, 0, 0, {3'd3, 6'b101000, 2'd0, 2'd0, 3'd0, 2'b01, 2'd0, 1'b0, 2'd0}, "lw_mem_wait");
        step(0, LW, 1, 0, {3'd3, 6'b101000, 2'd0, 2'd0, 3'd0, 2'b01, 2'd0, 1'b0, 2'd0}, "lw_mem_ready");
        step(0, LW, 0, 0, {3'd4, 6'b000011, 2'd0, 2'd1, 3'd0, 2'b01, 2'd0, 1'b0, 2'd0}, "lw_wb");

        // beq taken then not taken: PC write in EXEC, no register write
        step(0, BEQ, 1, 0, {3'd0, 6'b100100, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "beq1_fetch");
        check_instret(ret_exp(2), "lw_instret");
        step(0, BEQ, 0, 0, {3'd1, 6'b000000, 2'd0, 2'd0, 3'd2, 2'b00, 2'd0, 1'b0, 2'd0}, "beq1_decode");
        step(0, BEQ, 0, 1, {3'd2, 6'b000001, 2'd1, 2'd0, 3'd2, 2'b00, 2'd0, 1'b0, 2'd0}, "beq_taken_exec");
        step(0, BEQ, 1, 0, {3'd0, 6'b100100, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "beq2_fetch");
        step(0, BEQ, 0, 0, {3'd1, 6'b000000, 2'd0, 2'd0, 3'd2, 2'b00, 2'd0, 1'b0, 2'd0}, "beq2_decode");
        step(0, BEQ, 0, 0, {3'd2, 6'b000001, 2'd0, 2'd0, 3'd2, 2'b00, 2'd0, 1'b0, 2'd0}, "beq_not_taken_exec");

        // sw with zero-wait memory: 4 cycles, PC write on MEM exit
        step(0, SW, 1, 0, {3'd0, 6'b100100, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "sw_fetch");
        check_instret(ret_exp(4), "beq_instret");
        step(0, SW, 0, 0, {3'd1, 6'b000000, 2'd0, 2'd0, 3'd1, 2'b00, 2'd0, 1'b0, 2'd0}, "sw_decode");
        step(0, SW, 0, 0, {3'd2, 6'b000000, 2'd0, 2'd0, 3'd1, 2'b01, 2'd0, 1'b0, 2'd0}, "sw_exec");
        step(0, SW, 1, 0, {3'd3, 6'b111001, 2'd0, 2'd0, 3'd1, 2'b01, 2'd0, 1'b0, 2'd0}, "sw_mem");

        // illegal opcode 0x7F: TRAP after DECODE, held 20 cycles
        step(0, ILL, 1, 0, {3'd0, 6'b100100, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "ill_fetch");
        check_instret(ret_exp(5), "sw_instret");
        step(0, ILL, 0, 0, {3'd1, 6'b000000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "ill_decode");
        for (int i = 0; i < 20; i++)
            step(0, ILL, 1, 0, {3'd5, 6'b000000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b1, 2'd1}, "ill_trap_hold");
        check_instret(ret_exp(5), "ill_instret");
        step(1, ADDI, 0, 0, {3'd5, 6'b000000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b1, 2'd1}, "ill_reset");

        // memory timeout: 4 stalled FETCH cycles then TRAP cause 2
        for (int i = 0; i < 4; i++)
            step(0, ADDI, 0, 0, {3'd0, 6'b100000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "to_stall");
        check_instret(32'd0, "reset_clears_instret");
        step(0, ADDI, 1, 0, {3'd5, 6'b000000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b1, 2'd2}, "to_trap");
        step(1, ADDI, 0, 0, {3'd5, 6'b000000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b1, 2'd2}, "to_reset");

        // mem_ready on the 4th stall cycle wins over the timeout
        for (int i = 0; i < 3; i++)
            step(0, ADDI, 0, 0, {3'd0, 6'b100000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "nt_stall");
        step(0, ADDI, 1, 0, {3'd0, 6'b100100, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "nt_ready");
        step(0, ADDI, 0, 0, {3'd1, 6'b000000, 2'd0, 2'd0, 3'd0, 2'b00, 2'd0, 1'b0, 2'd0}, "nt_decode");
        step(0, ADDI, 0, 0, {3'd2, 6'b000000, 2'd0, 2'd0, 3'd0, 2'b01, 2'd1, 1'b0, 2'd0}, "nt_exec");
        step(0, ADDI, 0, 0, {3'd4, 6'b000011, 2'd0, 2'd0, 3'd0, 2'b01, 2'd1, 1'b0, 2'd0}, "nt_wb");
        step(1, SW, 0, 0, {3'd0, 6'b000000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "pre_sw_reset");
        check_instret(ret_exp(1), "nt_instret");

        // reset in MEM of a sw: no memory write, no PC write, FETCH resumes
        step(0, SW, 1, 0, {3'd0, 6'b100100, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "rsw_fetch");
        check_instret(32'd0, "rsw_instret_start");
        step(0, SW, 0, 0, {3'd1, 6'b000000, 2'd0, 2'd0, 3'd1, 2'b00, 2'd0, 1'b0, 2'd0}, "rsw_decode");
        step(0, SW, 0, 0, {3'd2, 6'b000000, 2'd0, 2'd0, 3'd1, 2'b01, 2'd0, 1'b0, 2'd0}, "rsw_exec");
        step(1, SW, 1, 0, {3'd3, 6'b001000, 2'd0, 2'd0, 3'd1, 2'b01, 2'd0, 1'b0, 2'd0}, "rsw_mem_reset");
        step(0, SW, 0, 0, {3'd0, 6'b100000, 2'd0, 2'd0, 3'd7, 2'b00, 2'd0, 1'b0, 2'd0}, "rsw_refetch");
        check_instret(32'd0, "rsw_instret_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
